pe_tx_scheduler: RTL and testbench



---
 rtl/pe_tx_scheduler.sv | 152 +++++++++++++++
 tb/tb_pe_tx_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pe_tx_scheduler.sv
// PE transmit scheduler: arbitrates retransmission, request and normal traffic,
// builds the 32-bit packet and holds it on the router injection port until accepted.
module pe_tx_scheduler #(
    parameter logic [2:0] MY_ID    = 3'b000,
    parameter logic [2:0] TAR_ID   = 3'b001,
    parameter logic [7:0] SEND_GAP = 8'd4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         dbg_mode,
    input  logic [7:0]   data_miss_vec,
    input  logic [7:0]   long_time_vec,
    input  logic [127:0] diff_counter_bus,
    input  logic [127:0] retrans_counter_bus,
    input  logic         ready_p2r,
    output logic [31:0]  data_p2r,
    output logic         valid_p2r,
    output logic         request_out_flag,
    output logic         retrans_out_flag,
    output logic         hold_out_flag,
    output logic [2:0]   request_dst,
    output logic [2:0]   retrans_dst,
    output logic         task_send_finish_flag
);

    localparam int unsigned NUM_TARGETS = 8;
    localparam int unsigned SEQ_W       = 17;
    localparam logic [1:0]  TYPE_NORMAL  = 2'b01;
    localparam logic [1:0]  TYPE_REQUEST = 2'b10;
    localparam logic [1:0]  TYPE_RETRANS = 2'b11;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [7:0]         time_stamp;
    logic [2:0]         rt_ptr, rq_ptr;
    logic [SEQ_W-1:0]   seq_next;
    logic [SEQ_W-1:0]   last_seq;
    logic [7:0]         gap_cnt;
    logic [7:0]         rt_vec, rq_vec;
    logic [3:0]         rt_pick, rq_pick;
    logic               normal_ok, issue, accept;
    logic [1:0]         pick_type;
    logic [2:0]         pick_dst;
    logic [15:0]        pick_data;

    // Returns {hit, index} of the first set bit at or after ptr, wrapping mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] ptr);
        logic [2:0] idx;
        rr_pick = 4'd0;
        for (int k = NUM_TARGETS - 1; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (vec[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    always_comb begin
        rt_vec = 8'd0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            rt_vec[i] = |retrans_counter_bus[16*i +: 16];
        end
    end

    assign rq_vec    = data_miss_vec | long_time_vec;
    assign rt_pick   = rr_pick(rt_vec, rt_ptr);
    assign rq_pick   = rr_pick(rq_vec, rq_ptr);
    assign normal_ok = !task_send_finish_flag && (gap_cnt == 8'd0);
    assign last_seq  = dbg_mode ? SEQ_W'(255) : SEQ_W'(65535);
    assign hold_out_flag = valid_p2r && !ready_p2r;

    // Next state and winning candidate; priority retrans > request > normal.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        accept    = 1'b0;
        pick_type = TYPE_NORMAL;
        pick_dst  = TAR_ID;
        pick_data = seq_next[15:0];
        if (rt_pick[3]) begin
            pick_type = TYPE_RETRANS;
            pick_dst  = rt_pick[2:0];
            pick_data = retrans_counter_bus[{rt_pick[2:0], 4'b0000} +: 16];
        end else if (rq_pick[3]) begin
            pick_type = TYPE_REQUEST;
            pick_dst  = rq_pick[2:0];
            pick_data = data_miss_vec[rq_pick[2:0]] ?
                        diff_counter_bus[{rq_pick[2:0], 4'b0000} +: 16] : 16'd0;
        end
        case (state_q)
            IDLE: begin
                if (enable && (rt_pick[3] || rq_pick[3] || normal_ok)) begin
                    issue   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready_p2r) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q               <= IDLE;
            time_stamp            <= 8'd0;
            rt_ptr                <= 3'd0;
            rq_ptr                <= 3'd0;
            seq_next              <= '0;
            gap_cnt               <= 8'd0;
            data_p2r              <= 32'd0;
            valid_p2r             <= 1'b0;
            request_out_flag      <= 1'b0;
            retrans_out_flag      <= 1'b0;
            request_dst           <= 3'd0;
            retrans_dst           <= 3'd0;
            task_send_finish_flag <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enable) time_stamp <= time_stamp + 8'd1;
            if (state_q == IDLE && enable && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
            if (issue) begin
                data_p2r         <= {pick_data, time_stamp, pick_type, MY_ID, pick_dst};
                valid_p2r        <= 1'b1;
                request_out_flag <= (pick_type == TYPE_REQUEST);
                retrans_out_flag <= (pick_type == TYPE_RETRANS);
                request_dst      <= (pick_type == TYPE_REQUEST) ? pick_dst : 3'd0;
                retrans_dst      <= (pick_type == TYPE_RETRANS) ? pick_dst : 3'd0;
            end
            // Acceptance: release the port and advance the winning class.
            if (accept) begin
                valid_p2r        <= 1'b0;
                request_out_flag <= 1'b0;
                retrans_out_flag <= 1'b0;
                request_dst      <= 3'd0;
                retrans_dst      <= 3'd0;
                if (retrans_out_flag) rt_ptr <= retrans_dst + 3'd1;
                if (request_out_flag) rq_ptr <= request_dst + 3'd1;
                if (data_p2r[7:6] == TYPE_NORMAL) begin
                    seq_next <= seq_next + SEQ_W'(1);
                    gap_cnt  <= SEND_GAP;
                    if (seq_next == last_seq) task_send_finish_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_tx_scheduler.sv
// Directed bench for pe_tx_scheduler: normal, request, retransmission, reset
// and debug-mode task completion with hand-computed packets.
module tb_pe_tx_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         dbg_mode;
    logic [7:0]   data_miss_vec;
    logic [7:0]   long_time_vec;
    logic [127:0] diff_counter_bus;
    logic [127:0] retrans_counter_bus;
    logic         ready_p2r;
    logic [31:0]  data_p2r;
    logic         valid_p2r;
    logic         request_out_flag;
    logic         retrans_out_flag;
    logic         hold_out_flag;
    logic [2:0]   request_dst;
    logic [2:0]   retrans_dst;
    logic         task_send_finish_flag;

    int n_cmp = 0;
    int n_bad = 0;

    pe_tx_scheduler #(.MY_ID(3'b000), .TAR_ID(3'b001), .SEND_GAP(8'd0)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable                (enable),
        .dbg_mode              (dbg_mode),
        .data_miss_vec         (data_miss_vec),
        .long_time_vec         (long_time_vec),
        .diff_counter_bus      (diff_counter_bus),
        .retrans_counter_bus   (retrans_counter_bus),
        .ready_p2r             (ready_p2r),
        .data_p2r              (data_p2r),
        .valid_p2r             (valid_p2r),
        .request_out_flag      (request_out_flag),
        .retrans_out_flag      (retrans_out_flag),
        .hold_out_flag         (hold_out_flag),
        .request_dst           (request_dst),
        .retrans_dst           (retrans_dst),
        .task_send_finish_flag (task_send_finish_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {valid, request, retrans, hold, finish}
    function automatic logic [31:0] flags();
        return 32'({valid_p2r, request_out_flag, retrans_out_flag, hold_out_flag, task_send_finish_flag});
    endfunction

    initial begin
        rst_n = 1'b0; enable = 1'b0; dbg_mode = 1'b0; ready_p2r = 1'b1;
        data_miss_vec = 8'h00; long_time_vec = 8'h00;
        diff_counter_bus = '0; retrans_counter_bus = '0;
        tick(); tick();
        chk("reset_flags", flags(), 32'h0);
        chk("reset_data", data_p2r, 32'h0);
        chk("reset_dst", 32'({request_dst, retrans_dst}), 32'h0);

        // Back-to-back normals: seq 0,1,2 with decision-cycle time stamps 0,2,4
        rst_n = 1'b1; enable = 1'b1;
        tick();
        chk("norm0_data", data_p2r, 32'h0000_0041);
        chk("norm0_flags", flags(), 32'b10000);
        tick();
        chk("norm0_drop", flags(), 32'b00000);
        tick();
        chk("norm1_data", data_p2r, 32'h0001_0241);
        tick(); tick();
        chk("norm2_data", data_p2r, 32'h0002_0441);
        tick();

        // Data-miss request to target 2 held for three cycles
        data_miss_vec = 8'h04;
        diff_counter_bus[47:32]   = 16'd3;
        diff_counter_bus[127:112] = 16'h1234;
        ready_p2r = 1'b0;
        tick();
        chk("req_data", data_p2r, 32'h0003_0682);
        chk("req_hold1", flags(), 32'b11010);
        chk("req_dst", 32'(request_dst), 32'd2);
        diff_counter_bus[47:32] = 16'd9;
        tick();
        chk("req_hold2", flags(), 32'b11010);
        chk("req_stable", data_p2r, 32'h0003_0682);
        tick();
        chk("req_hold3", flags(), 32'b11010);
        ready_p2r = 1'b1; data_miss_vec = 8'h00;
        #1;
        chk("req_accept", flags(), 32'b11000);
        tick();
        chk("req_done", flags(), 32'b00000);

        // Retrans to 1 and 5 plus request to 3, all at once
        retrans_counter_bus[31:16] = 16'd1;
        retrans_counter_bus[95:80] = 16'd2;
        data_miss_vec = 8'h08;
        diff_counter_bus[63:48] = 16'h0055;
        tick();
        chk("rt1_data", data_p2r, 32'h0001_0AC1);
        chk("rt1_flags", flags(), 32'b10100);
        chk("rt1_dst", 32'(retrans_dst), 32'd1);
        tick();
        retrans_counter_bus[31:16] = 16'd0;
        tick();
        chk("rt5_data", data_p2r, 32'h0002_0CC5);
        chk("rt5_dst", 32'(retrans_dst), 32'd5);
        tick();
        retrans_counter_bus[95:80] = 16'd0;
        tick();
        chk("rq3_data", data_p2r, 32'h0055_0E83);
        chk("rq3_flags", flags(), 32'b11000);
        chk("rq3_dst", 32'(request_dst), 32'd3);
        tick();
        data_miss_vec = 8'h00;
        tick();
        chk("norm3_data", data_p2r, 32'h0003_1041);
        tick();

        // Long-time request to target 7 carries zero data
        long_time_vec = 8'h80;
        tick();
        chk("lt7_data", data_p2r, 32'h0000_1287);
        chk("lt7_dst", 32'(request_dst), 32'd7);
        tick();
        long_time_vec = 8'h00;
        ready_p2r = 1'b0;

        // Reset while a normal packet is stalled
        tick();
        chk("stall_data", data_p2r, 32'h0004_1441);
        chk("stall_flags", flags(), 32'b10010);
        rst_n = 1'b0;
        tick();
        chk("midrst_flags", flags(), 32'b00000);
        chk("midrst_data", data_p2r, 32'h0);
        rst_n = 1'b1; ready_p2r = 1'b1;
        tick();
        chk("postrst_seq0", data_p2r, 32'h0000_0041);
        tick();

        // Enable low freezes time stamp and blocks issue
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("disabled_idle", flags(), 32'b00000);
        end
        enable = 1'b1;
        tick();
        chk("frozen_time", data_p2r, 32'h0001_0241);
        tick();

        // Debug-mode task of 256 packets
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; dbg_mode = 1'b1;
        for (int s = 0; s < 256; s++) begin
            tick();
            chk("dbg_seq", 32'({valid_p2r, task_send_finish_flag, data_p2r[31:16]}),
                32'({2'b10, 16'(s)}));
            tick();
        end
        chk("dbg_finish", flags(), 32'b00001);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("dbg_no_more", flags(), 32'b00001);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
